// File: rtl/isa_multislot_backplane_if.sv
// rtl/isa_multislot_backplane_if.sv - host strobes, per-slot card lines and merged bus outputs
interface isa_multislot_backplane_if #(
    parameter int NUM_SLOTS = 8,
    parameter int DATA_W    = 8
);
    logic                          bus_ior_n;
    logic                          bus_iow_n;
    logic                          bus_memr_n;
    logic                          bus_memw_n;
    logic [NUM_SLOTS-1:0]          card_sd_oe;
    logic [NUM_SLOTS*DATA_W-1:0]   card_sd_out;
    logic [NUM_SLOTS-1:0]          card_io_ch_rdy;
    logic [NUM_SLOTS-1:0]          card_io_ch_ck_n;
    logic [NUM_SLOTS*6-1:0]        card_irq;
    logic [DATA_W-1:0]             bus_sd_rd;
    logic                          bus_io_ch_rdy;
    logic                          bus_io_ch_ck_n;
    logic [5:0]                    bus_irq;
    logic [5:0]                    bus_irq_rise;
    logic                          sd_contention;
    logic                          timeout_err;

    modport master (
        output bus_ior_n, bus_iow_n, bus_memr_n, bus_memw_n,
        output card_sd_oe, card_sd_out, card_io_ch_rdy, card_io_ch_ck_n, card_irq,
        input  bus_sd_rd, bus_io_ch_rdy, bus_io_ch_ck_n, bus_irq, bus_irq_rise,
        input  sd_contention, timeout_err
    );

    modport slave (
        input  bus_ior_n, bus_iow_n, bus_memr_n, bus_memw_n,
        input  card_sd_oe, card_sd_out, card_io_ch_rdy, card_io_ch_ck_n, card_irq,
        output bus_sd_rd, bus_io_ch_rdy, bus_io_ch_ck_n, bus_irq, bus_irq_rise,
        output sd_contention, timeout_err
    );
endinterface

// File: rtl/isa_multislot_backplane.sv
// rtl/isa_multislot_backplane.sv - resolves card drivers onto one ISA bus with wait-state timeout
module isa_multislot_backplane #(
    parameter int                NUM_SLOTS       = 8,
    parameter int                DATA_W          = 8,
    parameter int                WAIT_LIMIT      = 64,
    parameter bit                CHCK_ON_TIMEOUT = 1'b1,
    parameter logic [DATA_W-1:0] FLOAT_VALUE     = '1
) (
    input  logic                            bus_clk,
    input  logic                            bus_reset_drv,
    isa_multislot_backplane_if.slave        bus
);
    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_WAIT, S_TIMEOUT} state_t;

    state_t             state, next_state;
    logic [CNT_W-1:0]   wait_cnt, wait_cnt_d;
    logic               rd_q, wr_q, cmd_q;
    logic               all_rdy;
    logic               rdy_d, ck_n_d, timeout_d;
    logic [DATA_W-1:0]  rd_data;
    logic               oe_found, oe_multi;
    logic [5:0]         irq_or;

    assign all_rdy = &bus.card_io_ch_rdy;

    always_ff @(posedge bus_clk) begin
        if (bus_reset_drv) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= wait_cnt_d;
        end
    end

    // Strobe release wins over both recovery and timeout while waiting.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (cmd_q) next_state = S_ACTIVE;
            S_ACTIVE:  if (!cmd_q) next_state = S_IDLE;
                       else if (!all_rdy) next_state = S_WAIT;
            S_WAIT:    if (!cmd_q) next_state = S_IDLE;
                       else if (all_rdy) next_state = S_ACTIVE;
                       else if (wait_cnt == CNT_W'(WAIT_LIMIT - 1)) next_state = S_TIMEOUT;
            S_TIMEOUT: if (!cmd_q) next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    always_comb begin
        wait_cnt_d = '0;
        if (state == S_WAIT && (next_state == S_WAIT || next_state == S_TIMEOUT))
            wait_cnt_d = (&wait_cnt) ? wait_cnt : wait_cnt + CNT_W'(1);
        else if (state == S_TIMEOUT && next_state == S_TIMEOUT)
            wait_cnt_d = wait_cnt;
        rdy_d     = (state == S_IDLE || state == S_TIMEOUT) ? 1'b1 : all_rdy;
        ck_n_d    = (&bus.card_io_ch_ck_n) & ~(CHCK_ON_TIMEOUT && state == S_TIMEOUT);
        timeout_d = (state == S_WAIT) && (next_state == S_TIMEOUT);
    end

    // Lowest-index enabled slot wins; any second enable is flagged as multi-drive.
    always_comb begin
        rd_data  = FLOAT_VALUE;
        oe_found = 1'b0;
        oe_multi = 1'b0;
        irq_or   = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (bus.card_sd_oe[i]) begin
                if (oe_found) begin
                    oe_multi = 1'b1;
                end else begin
                    rd_data  = bus.card_sd_out[i*DATA_W +: DATA_W];
                    oe_found = 1'b1;
                end
            end
            irq_or = irq_or | bus.card_irq[i*6 +: 6];
        end
    end

    always_ff @(posedge bus_clk) begin
        if (bus_reset_drv) begin
            rd_q               <= 1'b0;
            wr_q               <= 1'b0;
            cmd_q              <= 1'b0;
            bus.bus_sd_rd      <= FLOAT_VALUE;
            bus.bus_io_ch_rdy  <= 1'b1;
            bus.bus_io_ch_ck_n <= 1'b1;
            bus.bus_irq        <= '0;
            bus.bus_irq_rise   <= '0;
            bus.sd_contention  <= 1'b0;
            bus.timeout_err    <= 1'b0;
        end else begin
            rd_q               <= ~bus.bus_ior_n | ~bus.bus_memr_n;
            wr_q               <= ~bus.bus_iow_n | ~bus.bus_memw_n;
            cmd_q              <= ~bus.bus_ior_n | ~bus.bus_memr_n | ~bus.bus_iow_n | ~bus.bus_memw_n;
            if (rd_q)
                bus.bus_sd_rd  <= rd_data;
            bus.bus_io_ch_rdy  <= rdy_d;
            bus.bus_io_ch_ck_n <= ck_n_d;
            bus.bus_irq        <= irq_or;
            bus.bus_irq_rise   <= irq_or & ~bus.bus_irq;
            bus.sd_contention  <= bus.sd_contention | (rd_q & oe_multi) | (wr_q & |bus.card_sd_oe);
            bus.timeout_err    <= timeout_d;
        end
    end
endmodule

// File: tb/tb_isa_multislot_backplane.sv
// tb/tb_isa_multislot_backplane.sv - directed checks of the 4-slot backplane with an 8-cycle wait limit
module tb_isa_multislot_backplane;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    isa_multislot_backplane_if #(.NUM_SLOTS(4), .DATA_W(8)) bus_if ();

    isa_multislot_backplane #(
        .NUM_SLOTS(4), .DATA_W(8), .WAIT_LIMIT(8), .CHCK_ON_TIMEOUT(1'b1), .FLOAT_VALUE(8'hFF)
    ) dut (
        .bus_clk(clk),
        .bus_reset_drv(rst),
        .bus(bus_if)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        bus_if.bus_ior_n       = 1'b1;
        bus_if.bus_iow_n       = 1'b1;
        bus_if.bus_memr_n      = 1'b1;
        bus_if.bus_memw_n      = 1'b1;
        bus_if.card_sd_oe      = '0;
        bus_if.card_sd_out     = '0;
        bus_if.card_io_ch_rdy  = '1;
        bus_if.card_io_ch_ck_n = '1;
        bus_if.card_irq        = '0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_sd_rd"}, 32'(bus_if.bus_sd_rd), 32'hFF);
        check({tag, "_rdy"},   32'(bus_if.bus_io_ch_rdy), 32'd1);
        check({tag, "_ck_n"},  32'(bus_if.bus_io_ch_ck_n), 32'd1);
        check({tag, "_irq"},   32'(bus_if.bus_irq), 32'd0);
        check({tag, "_rise"},  32'(bus_if.bus_irq_rise), 32'd0);
        check({tag, "_cont"},  32'(bus_if.sd_contention), 32'd0);
        check({tag, "_tmo"},   32'(bus_if.timeout_err), 32'd0);
    endtask

    initial begin
        int low_cnt, pulses, first_t, rel_t, rises;
        logic tmo_seen;

        idle_inputs();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        check_reset_vals("reset");

        // single driver read, then hold while strobe is idle
        bus_if.card_sd_oe = 4'b0100;
        bus_if.card_sd_out[2*8 +: 8] = 8'h5A;
        bus_if.bus_ior_n = 1'b0;
        tick(2);
        check("rd_slot2", 32'(bus_if.bus_sd_rd), 32'h5A);
        tick(1);
        bus_if.bus_ior_n = 1'b1;
        tick(1);
        bus_if.card_sd_out[2*8 +: 8] = 8'h00;
        tick(1);
        check("rd_hold", 32'(bus_if.bus_sd_rd), 32'h5A);
        check("rd_no_cont", 32'(bus_if.sd_contention), 32'd0);
        idle_inputs();
        tick(2);

        // floating bus, then two drivers
        bus_if.bus_ior_n = 1'b0;
        tick(2);
        check("rd_float", 32'(bus_if.bus_sd_rd), 32'hFF);
        bus_if.card_sd_oe = 4'b1010;
        bus_if.card_sd_out[1*8 +: 8] = 8'h11;
        bus_if.card_sd_out[3*8 +: 8] = 8'h33;
        tick(1);
        check("rd_prio", 32'(bus_if.bus_sd_rd), 32'h11);
        check("rd_cont_set", 32'(bus_if.sd_contention), 32'd1);
        idle_inputs();
        tick(3);
        check("cont_sticky", 32'(bus_if.sd_contention), 32'd1);

        // card driving during a write is contention too
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("wr_cont_clr", 32'(bus_if.sd_contention), 32'd0);
        bus_if.bus_iow_n = 1'b1;
        bus_if.bus_memw_n = 1'b0;
        tick(2);
        check("wr_no_oe", 32'(bus_if.sd_contention), 32'd0);
        bus_if.card_sd_oe = 4'b0001;
        tick(1);
        check("wr_oe_cont", 32'(bus_if.sd_contention), 32'd1);
        idle_inputs();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);

        // short wait: 5 not-ready cycles, no timeout
        bus_if.bus_memr_n = 1'b0;
        tick(2);
        bus_if.card_io_ch_rdy[0] = 1'b0;
        low_cnt = 0;
        tmo_seen = 1'b0;
        for (int t = 0; t < 5; t++) begin
            tick(1);
            if (bus_if.bus_io_ch_rdy == 1'b0) low_cnt++;
            tmo_seen |= bus_if.timeout_err;
        end
        check("wait_low_cycles", 32'(low_cnt), 32'd5);
        bus_if.card_io_ch_rdy[0] = 1'b1;
        tick(1);
        check("wait_recover", 32'(bus_if.bus_io_ch_rdy), 32'd1);
        bus_if.bus_memr_n = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick(1);
            tmo_seen |= bus_if.timeout_err;
        end
        check("wait_no_tmo", 32'(tmo_seen), 32'd0);

        // held not-ready: timeout after 8 wait cycles
        bus_if.bus_memr_n = 1'b0;
        tick(2);
        bus_if.card_io_ch_rdy[0] = 1'b0;
        pulses = 0;
        first_t = 0;
        for (int t = 1; t <= 20; t++) begin
            tick(1);
            if (bus_if.timeout_err) begin
                pulses++;
                if (first_t == 0) first_t = t;
            end
        end
        check("tmo_pulses", 32'(pulses), 32'd1);
        check("tmo_when", 32'(first_t), 32'd9);
        check("tmo_rdy", 32'(bus_if.bus_io_ch_rdy), 32'd1);
        check("tmo_ck_n", 32'(bus_if.bus_io_ch_ck_n), 32'd0);
        bus_if.bus_memr_n = 1'b1;
        rel_t = 0;
        for (int t = 1; t <= 10; t++) begin
            tick(1);
            if (rel_t == 0 && bus_if.bus_io_ch_ck_n == 1'b1) rel_t = t;
        end
        check("tmo_release", 32'(rel_t), 32'd3);
        bus_if.card_io_ch_rdy[0] = 1'b1;
        tick(1);

        // card channel check passes through
        bus_if.card_io_ch_ck_n[2] = 1'b0;
        tick(1);
        check("card_ck_n", 32'(bus_if.bus_io_ch_ck_n), 32'd0);
        bus_if.card_io_ch_ck_n[2] = 1'b1;
        tick(1);
        check("card_ck_n_rel", 32'(bus_if.bus_io_ch_ck_n), 32'd1);

        // two slots raise IRQ3 together
        bus_if.card_irq[0*6 + 1] = 1'b1;
        bus_if.card_irq[3*6 + 1] = 1'b1;
        tick(1);
        check("irq_level", 32'(bus_if.bus_irq), 32'h02);
        check("irq_rise", 32'(bus_if.bus_irq_rise), 32'h02);
        rises = 0;
        for (int t = 0; t < 4; t++) begin
            tick(1);
            if (bus_if.bus_irq_rise != 6'd0) rises++;
            if (t == 1) bus_if.card_irq[0*6 + 1] = 1'b0;
        end
        check("irq_single_pulse", 32'(rises), 32'd0);
        check("irq_still_high", 32'(bus_if.bus_irq), 32'h02);
        bus_if.card_irq = '0;
        tick(1);
        check("irq_drop", 32'(bus_if.bus_irq), 32'h00);

        // reset while waiting, with contention and IRQ active
        bus_if.bus_ior_n = 1'b0;
        bus_if.bus_iow_n = 1'b0;
        bus_if.card_sd_oe = 4'b0001;
        bus_if.card_sd_out[0*8 +: 8] = 8'h3C;
        bus_if.card_irq[2*6 + 5] = 1'b1;
        tick(2);
        bus_if.card_io_ch_rdy[0] = 1'b0;
        tick(3);
        check("pre_rst_rd", 32'(bus_if.bus_sd_rd), 32'h3C);
        check("pre_rst_cont", 32'(bus_if.sd_contention), 32'd1);
        check("pre_rst_rdy", 32'(bus_if.bus_io_ch_rdy), 32'd0);
        check("pre_rst_irq", 32'(bus_if.bus_irq), 32'h20);
        rst = 1'b1;
        tick(1);
        check_reset_vals("rst_wait");
        idle_inputs();
        rst = 1'b0;
        tick(2);
        check("post_rst_rdy", 32'(bus_if.bus_io_ch_rdy), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
